// File: rtl/sseg_scan_ctrl.sv
// IOBUS-mapped controller for the Basys3 4-digit seven-segment display.
// Holds a 16-bit hex value and a control byte; multiplexes one digit per refresh slot.
module sseg_scan_ctrl #(
  parameter logic [31:0] DATA_ADDR   = 32'h1100C00C,
  parameter logic [31:0] CTRL_ADDR   = 32'h1100C010,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] rd_data,
  output logic [7:0]  segs,
  output logic [3:0]  an
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]      r_data;
  logic [7:0]       r_ctrl;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;

  logic             w_en;
  logic             w_wr_data;
  logic             w_wr_ctrl;
  logic [3:0]       w_nib;
  logic [6:0]       w_hex;
  logic [3:0]       w_dpm;
  logic             w_upper_zero;
  logic             w_blank;
  logic [3:0]       w_an_next;
  logic [7:0]       w_segs_next;

  assign w_en      = r_ctrl[0];
  assign w_wr_data = IOBUS_WR && (IOBUS_ADDR == DATA_ADDR);
  assign w_wr_ctrl = IOBUS_WR && (IOBUS_ADDR == CTRL_ADDR);
  assign w_dpm     = r_ctrl[7:4];

  // Nibble and leading-zero test for the digit about to be shown
  always_comb begin
    w_nib        = r_data[3:0];
    w_upper_zero = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib        = r_data[3:0];
        w_upper_zero = 1'b0;
      end
      2'd1: begin
        w_nib        = r_data[7:4];
        w_upper_zero = (r_data[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib        = r_data[11:8];
        w_upper_zero = (r_data[15:8] == 8'h00);
      end
      default: begin
        w_nib        = r_data[15:12];
        w_upper_zero = (r_data[15:12] == 4'h0);
      end
    endcase
  end

  // Active-low segment decode, bit 0 = A .. bit 6 = G
  always_comb begin
    w_hex = 7'h7F;
    case (w_nib)
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      default: w_hex = 7'h0E;
    endcase
  end

  assign w_blank = r_ctrl[1] && w_upper_zero;

  always_comb begin
    w_an_next   = ~(4'b0001 << r_idx);
    w_segs_next = {~w_dpm[r_idx], w_hex};
    if (w_blank) begin
      w_an_next   = 4'hF;
      w_segs_next = 8'hFF;
    end
  end

  always_comb begin
    rd_data = 32'h0;
    if (IOBUS_ADDR == DATA_ADDR) begin
      rd_data = {16'h0, r_data};
    end else if (IOBUS_ADDR == CTRL_ADDR) begin
      rd_data = {24'h0, r_ctrl};
    end
  end

  // Register writes run independently of the scan; scan sees pre-write values
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_data <= 16'h0000;
      r_ctrl <= 8'h01;
    end else begin
      if (w_wr_data) begin
        r_data <= IOBUS_OUT[15:0];
      end
      if (w_wr_ctrl) begin
        r_ctrl <= {IOBUS_OUT[7:4], 2'b00, IOBUS_OUT[1:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
      an    <= 4'hF;
      segs  <= 8'hFF;
    end else if (!w_en) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
      an    <= 4'hF;
      segs  <= 8'hFF;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
      an    <= w_an_next;
      segs  <= w_segs_next;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: directed scenarios plus random bus traffic,
// checked every cycle against a slot-arithmetic model of the display.
module tb_sseg_scan_ctrl;

  localparam int unsigned DIV = 4;
  localparam logic [31:0] DA  = 32'h1100C00C;
  localparam logic [31:0] CA  = 32'h1100C010;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] rd_data;
  logic [7:0]  segs;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  sseg_scan_ctrl #(.DATA_ADDR(DA), .CTRL_ADDR(CA), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .RESET_N(RESET_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .rd_data(rd_data), .segs(segs), .an(an)
  );

  always #5 clk = ~clk;

  logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: register contents, enabled-cycle count, expected display
  logic [15:0] m_data;
  logic [7:0]  m_ctrl;
  int          m_t;
  logic [3:0]  m_an;
  logic [7:0]  m_segs;

  function automatic logic [11:0] pattern(input logic [15:0] d, input logic [7:0] c, input int k);
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [7:0]  h;
    upper = d >> (4 * k);
    if (k > 0 && c[1] && upper == 16'h0) return 12'hFFF;
    nib = upper[3:0];
    h = HEX[nib];
    return {4'hF ^ 4'(1 << k), ~c[4 + k], h[6:0]};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a == DA) return {16'h0, m_data};
    if (a == CA) return {24'h0, m_ctrl};
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_data = 16'h0; m_ctrl = 8'h01; m_t = 0; m_an = 4'hF; m_segs = 8'hFF;
  endtask

  task automatic model_edge();
    logic [11:0] p;
    if (!RESET_N) return;
    if (!m_ctrl[0]) begin
      m_an = 4'hF; m_segs = 8'hFF; m_t = 0;
    end else begin
      if (m_t % DIV == DIV - 1) begin
        p = pattern(m_data, m_ctrl, (m_t / DIV) % 4);
        m_an = p[11:8]; m_segs = p[7:0];
      end
      m_t++;
    end
    if (IOBUS_WR && IOBUS_ADDR == DA) m_data = IOBUS_OUT[15:0];
    if (IOBUS_WR && IOBUS_ADDR == CA) m_ctrl = {IOBUS_OUT[7:4], 2'b00, IOBUS_OUT[1:0]};
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = 1'b1;
    tick();
    IOBUS_WR = 1'b0;
  endtask

  task automatic run_scan(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (an !== m_an || segs !== m_segs) begin
        errors++;
        $display("FAIL %s cyc %0d: an=%h segs=%h expected an=%h segs=%h", name, i, an, segs, m_an, m_segs);
      end
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; IOBUS_ADDR = DA; IOBUS_OUT = 32'h0; IOBUS_WR = 1'b0;
    model_reset();
    #12;
    checks++;
    if (an !== 4'hF || segs !== 8'hFF) begin
      errors++;
      $display("FAIL reset_disp: an=%h segs=%h expected an=f segs=ff", an, segs);
    end
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rd=%h expected 00000000", rd_data);
    end
    IOBUS_ADDR = CA;
    #1;
    checks++;
    if (rd_data !== 32'h1) begin
      errors++;
      $display("FAIL reset_ctrl: rd=%h expected 00000001", rd_data);
    end
    @(negedge clk);
    RESET_N = 1'b1;
  endtask

  task automatic test_first_frame();
    run_scan("first_frame", 6 * DIV);
  endtask

  task automatic test_hex_data();
    bus_write(DA, 32'hFFFF1A8F);
    IOBUS_ADDR = DA;
    #1;
    checks++;
    if (rd_data !== 32'h00001A8F) begin
      errors++;
      $display("FAIL data_rd: rd=%h expected 00001a8f", rd_data);
    end
    run_scan("hex_1a8f", 5 * DIV);
  endtask

  task automatic test_decode_all();
    logic [15:0] vals [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    for (int v = 0; v < 4; v++) begin
      bus_write(DA, {16'h0, vals[v]});
      run_scan("decode", 5 * DIV);
    end
  endtask

  task automatic test_blank();
    bus_write(CA, 32'h23);
    bus_write(DA, 32'h0005);
    run_scan("blank_0005", 5 * DIV);
    bus_write(DA, 32'h0105);
    run_scan("blank_0105", 5 * DIV);
    bus_write(CA, 32'hF3);
    bus_write(DA, 32'h0000);
    run_scan("blank_0000", 5 * DIV);
  endtask

  task automatic test_enable();
    bus_write(CA, 32'h01);
    bus_write(DA, 32'h4321);
    for (int i = 0; i < 8 * DIV && (m_t % (4 * DIV)) != 2 * DIV + 1; i++) tick();
    bus_write(CA, 32'h00);
    run_scan("en_off", 1);
    checks++;
    if (an !== 4'hF || segs !== 8'hFF) begin
      errors++;
      $display("FAIL en_off_blank: an=%h segs=%h expected an=f segs=ff", an, segs);
    end
    run_scan("en_idle", 2 * DIV);
    bus_write(DA, 32'h9876);
    bus_write(CA, 32'h01);
    run_scan("en_restart", DIV - 1);
    checks++;
    if (an !== 4'hF) begin
      errors++;
      $display("FAIL en_early: an=%h expected f", an);
    end
    run_scan("en_first", 1);
    checks++;
    if (an !== 4'hE || segs !== 8'h82) begin
      errors++;
      $display("FAIL en_digit0: an=%h segs=%h expected an=e segs=82", an, segs);
    end
    run_scan("en_frame", 4 * DIV);
  endtask

  task automatic test_addr_decode();
    logic [31:0] addrs [3] = '{32'h1100C000, 32'h1100C014, DA};
    bus_write(DA, 32'h0000BEEF);
    bus_write(CA, 32'h00000011);
    bus_write(32'h1100C000, 32'h12345678);
    bus_write(32'h1100C014, 32'h000000FF);
    for (int i = 0; i < 3; i++) begin
      IOBUS_ADDR = addrs[i];
      #1;
      checks++;
      if (rd_data !== exp_rd(addrs[i])) begin
        errors++;
        $display("FAIL addr_rd %h: rd=%h expected %h", addrs[i], rd_data, exp_rd(addrs[i]));
      end
    end
    IOBUS_ADDR = CA;
    #1;
    checks++;
    if (rd_data !== 32'h11) begin
      errors++;
      $display("FAIL ctrl_unchanged: rd=%h expected 00000011", rd_data);
    end
    // Read during a write returns the old value
    IOBUS_OUT = 32'hFF; IOBUS_WR = 1'b1;
    #1;
    checks++;
    if (rd_data !== 32'h11) begin
      errors++;
      $display("FAIL no_bypass: rd=%h expected 00000011", rd_data);
    end
    tick();
    IOBUS_WR = 1'b0;
    checks++;
    if (rd_data !== 32'hF3) begin
      errors++;
      $display("FAIL ctrl_mask: rd=%h expected 000000f3", rd_data);
    end
    run_scan("addr_scan", 4 * DIV);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] pick [4] = '{DA, CA, 32'h1100C000, 32'h1100C014};
    for (int i = 0; i < 600; i++) begin
      IOBUS_WR   = ($urandom_range(0, 5) == 0);
      IOBUS_ADDR = pick[$urandom_range(0, 3)];
      IOBUS_OUT  = $urandom;
      if (IOBUS_ADDR == CA && $urandom_range(0, 4) != 0) IOBUS_OUT[0] = 1'b1;
      run_scan("random", 1);
      IOBUS_WR = 1'b0;
      a = pick[$urandom_range(0, 3)];
      IOBUS_ADDR = a;
      #1;
      checks++;
      if (rd_data !== exp_rd(a)) begin
        errors++;
        $display("FAIL random_rd %h: rd=%h expected %h", a, rd_data, exp_rd(a));
      end
    end
  endtask

  task automatic test_async_reset();
    bus_write(CA, 32'h01);
    bus_write(DA, 32'h5A5A);
    run_scan("pre_reset", 2 * DIV + 1);
    @(negedge clk);
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    checks++;
    if (an !== 4'hF || segs !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset: an=%h segs=%h expected an=f segs=ff", an, segs);
    end
    IOBUS_ADDR = DA;
    #1;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL async_data: rd=%h expected 00000000", rd_data);
    end
    IOBUS_ADDR = CA;
    #1;
    checks++;
    if (rd_data !== 32'h1) begin
      errors++;
      $display("FAIL async_ctrl: rd=%h expected 00000001", rd_data);
    end
    @(negedge clk);
    RESET_N = 1'b1;
    run_scan("post_reset", 5 * DIV);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_hex_data();
    test_decode_all();
    test_blank();
    test_enable();
    test_addr_decode();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
